// File: rtl/inst_stage_sequencer_if.sv
// rtl/inst_stage_sequencer_if.sv - prefetch/scheduler handshake bundle for the instruction stage sequencer
interface inst_stage_sequencer_if #(
    parameter int INST_BITS  = 16,
    parameter int STAGE_BITS = 2
);
    logic                  in_valid;
    logic [INST_BITS-1:0]  in_inst;
    logic                  in_ready;
    logic                  flush;
    logic                  inst_valid;
    logic [INST_BITS-1:0]  inst;
    logic [STAGE_BITS-1:0] stage;
    logic                  final_stage;
    logic                  push_ret;
    logic                  sc_stage_done;
    logic                  inst_done;
    logic                  sc_next_imm_data;
    logic                  next_imm_data;

    modport slave (
        input  in_valid, in_inst, flush, sc_stage_done, sc_next_imm_data,
        output in_ready, inst_valid, inst, stage, final_stage, push_ret,
               inst_done, next_imm_data
    );

    modport master (
        output in_valid, in_inst, flush, sc_stage_done, sc_next_imm_data,
        input  in_ready, inst_valid, inst, stage, final_stage, push_ret,
               inst_done, next_imm_data
    );
endinterface

// File: rtl/inst_stage_sequencer.sv
// rtl/inst_stage_sequencer.sv - instruction FIFO and multi-stage call sequencer; optional INST_BYPASS_EN
module inst_stage_sequencer #(
    parameter int INST_BITS   = 16,
    parameter int QUEUE_DEPTH = 2,
    parameter int STAGE_BITS  = 2,
    parameter int CALL_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    inst_stage_sequencer_if.slave  bus
);
    localparam int PTR_BITS = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(QUEUE_DEPTH + 1);
    localparam logic [STAGE_BITS-1:0] CALL_LAST = STAGE_BITS'(CALL_STAGES - 1);
    localparam logic [PTR_BITS-1:0]   PTR_MAX   = PTR_BITS'(QUEUE_DEPTH - 1);
    localparam logic [CNT_BITS-1:0]   CNT_FULL  = CNT_BITS'(QUEUE_DEPTH);

    logic [INST_BITS-1:0]  mem_q [QUEUE_DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [STAGE_BITS-1:0] stage_q, stage_d;

    logic                  empty, full, bypass, head_valid, is_call, final_stg;
    logic                  stage_adv, retire, push, pop;
    logic [INST_BITS-1:0]  head;
    logic [STAGE_BITS-1:0] last_stage;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

`ifdef INST_BYPASS_EN
    assign bypass = empty && bus.in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign head       = bypass ? bus.in_inst : mem_q[rd_ptr_q];
    assign head_valid = !empty || bypass;
    // Gating on head_valid keeps an empty queue reading as single-stage/final.
    assign is_call    = head_valid && (head[15:6] == 10'b0010000001);
    assign last_stage = is_call ? CALL_LAST : '0;
    assign final_stg  = (stage_q == last_stage);
    assign stage_adv  = bus.sc_stage_done && head_valid;
    assign retire     = stage_adv && final_stg;
    // A bypassed single-stage instruction retiring this cycle never lands in the queue.
    assign push       = bus.in_valid && !full && !bus.flush && !(bypass && retire);
    assign pop        = retire && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stage_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stage_q  <= stage_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_inst;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stage_d  = stage_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            stage_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_BITS'(push) - CNT_BITS'(pop);
            if (retire) begin
                stage_d = '0;
            end else if (stage_adv) begin
                stage_d = stage_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready      = !full && !bus.flush;
        bus.inst_valid    = head_valid;
        bus.inst          = head;
        bus.stage         = stage_q;
        bus.final_stage   = final_stg;
        bus.push_ret      = is_call && !final_stg;
        bus.inst_done     = retire;
        bus.next_imm_data = bus.sc_next_imm_data && head_valid && final_stg;
    end
endmodule

// File: tb/tb_inst_stage_sequencer.sv
// tb/tb_inst_stage_sequencer.sv - self-checking bench for inst_stage_sequencer with a queue-based reference model
`timescale 1ns/1ps
module tb_inst_stage_sequencer;
    localparam int IB = 16;
    localparam int QD = 2;
    localparam int SB = 2;
    localparam int CS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    inst_stage_sequencer_if #(.INST_BITS(IB), .STAGE_BITS(SB)) bus ();

    inst_stage_sequencer #(
        .INST_BITS(IB), .QUEUE_DEPTH(QD), .STAGE_BITS(SB), .CALL_STAGES(CS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds buffered words in order, mstage is the head's micro-stage.
    logic [IB-1:0] mq[$];
    int mstage = 0;

    always @(negedge clk) begin : model_cmp
        bit            v, call, fin, rdy, done;
        logic [IB-1:0] h;
        int            last;
        #3;
        if (!reset_n) begin
            mq.delete();
            mstage = 0;
        end else begin
            v    = (mq.size() > 0);
            h    = v ? mq[0] : '0;
            call = v && (h[15:6] == 10'b0010000001);
            last = call ? CS - 1 : 0;
            fin  = (mstage == last);
            rdy  = (mq.size() < QD) && !bus.flush;
            done = bus.sc_stage_done && v && fin;
            check("m_in_ready", 32'(bus.in_ready), 32'(rdy));
            check("m_inst_valid", 32'(bus.inst_valid), 32'(v));
            if (v) check("m_inst", 32'(bus.inst), 32'(h));
            check("m_stage", 32'(bus.stage), 32'(mstage));
            check("m_final_stage", 32'(bus.final_stage), 32'(fin));
            check("m_push_ret", 32'(bus.push_ret), 32'(call && !fin));
            check("m_inst_done", 32'(bus.inst_done), 32'(done));
            check("m_next_imm", 32'(bus.next_imm_data), 32'(bus.sc_next_imm_data && v && fin));
            if (bus.flush) begin
                mq.delete();
                mstage = 0;
            end else begin
                if (bus.sc_stage_done && v) begin
                    if (fin) begin
                        void'(mq.pop_front());
                        mstage = 0;
                    end else begin
                        mstage++;
                    end
                end
                if (bus.in_valid && rdy) mq.push_back(bus.in_inst);
            end
        end
    end

    task automatic step(input bit iv, input logic [15:0] ii, input bit fl, input bit sd, input bit sn);
        @(negedge clk);
        bus.in_valid         = iv;
        bus.in_inst          = ii;
        bus.flush            = fl;
        bus.sc_stage_done    = sd;
        bus.sc_next_imm_data = sn;
        #3;
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_inst = 16'h8123;
        bus.flush = 1'b0;
        bus.sc_stage_done = 1'b0;
        bus.sc_next_imm_data = 1'b1;
        reset_n = 1'b0;

        step(1, 16'h8123, 0, 0, 1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_stage", 32'(bus.stage), 32'd0);
        check("rst_final", 32'(bus.final_stage), 32'd1);
        check("rst_push_ret", 32'(bus.push_ret), 32'd0);
        check("rst_inst_done", 32'(bus.inst_done), 32'd0);
        check("rst_next_imm", 32'(bus.next_imm_data), 32'd0);
        step(0, 16'h0000, 0, 0, 0);
        reset_n = 1'b1;

        step(1, 16'h8123, 0, 0, 0);
        check("push_not_visible", 32'(bus.inst_valid), 32'd0);
        step(0, 16'h0000, 0, 0, 0);
        check("single_valid", 32'(bus.inst_valid), 32'd1);
        check("single_inst", 32'(bus.inst), 32'h8123);
        check("single_final", 32'(bus.final_stage), 32'd1);
        check("single_push_ret", 32'(bus.push_ret), 32'd0);
        step(0, 16'h0000, 0, 1, 1);
        check("single_done", 32'(bus.inst_done), 32'd1);
        check("single_imm", 32'(bus.next_imm_data), 32'd1);

        step(1, 16'h2041, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 1);
        check("call_s0_stage", 32'(bus.stage), 32'd0);
        check("call_s0_push_ret", 32'(bus.push_ret), 32'd1);
        check("call_s0_final", 32'(bus.final_stage), 32'd0);
        check("call_s0_imm_gated", 32'(bus.next_imm_data), 32'd0);
        step(0, 16'h0000, 0, 1, 0);
        check("call_s0_no_done", 32'(bus.inst_done), 32'd0);
        step(0, 16'h0000, 0, 1, 0);
        check("call_s1_stage", 32'(bus.stage), 32'd1);
        check("call_s1_push_ret", 32'(bus.push_ret), 32'd1);
        check("call_s1_no_done", 32'(bus.inst_done), 32'd0);
        step(0, 16'h0000, 0, 0, 1);
        check("call_s2_stage", 32'(bus.stage), 32'd2);
        check("call_s2_final", 32'(bus.final_stage), 32'd1);
        check("call_s2_push_ret", 32'(bus.push_ret), 32'd0);
        check("call_s2_imm", 32'(bus.next_imm_data), 32'd1);
        step(0, 16'h0000, 0, 1, 0);
        check("call_s2_done", 32'(bus.inst_done), 32'd1);
        step(0, 16'h0000, 0, 0, 0);
        check("call_retired", 32'(bus.inst_valid), 32'd0);

        step(1, 16'hA001, 0, 0, 0);
        step(1, 16'hA002, 0, 0, 0);
        check("fill_ready_one", 32'(bus.in_ready), 32'd1);
        step(0, 16'h0000, 0, 0, 0);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        check("full_head", 32'(bus.inst), 32'hA001);
        step(1, 16'hA003, 0, 1, 0);
        check("full_retire_done", 32'(bus.inst_done), 32'd1);
        step(1, 16'hA003, 0, 1, 0);
        check("pushpop_head", 32'(bus.inst), 32'hA002);
        check("pushpop_ready", 32'(bus.in_ready), 32'd1);
        step(0, 16'h0000, 0, 0, 0);
        check("pushpop_order", 32'(bus.inst), 32'hA003);
        check("pushpop_count1", 32'(bus.in_ready), 32'd1);
        step(0, 16'h0000, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 0);
        check("drained", 32'(bus.inst_valid), 32'd0);

        step(1, 16'h2041, 0, 0, 0);
        step(1, 16'hB004, 0, 0, 0);
        step(0, 16'h0000, 0, 1, 0);
        step(1, 16'hC005, 1, 0, 0);
        check("flush_ready_low", 32'(bus.in_ready), 32'd0);
        check("flush_stage1", 32'(bus.stage), 32'd1);
        step(0, 16'h0000, 0, 0, 0);
        check("flush_empty", 32'(bus.inst_valid), 32'd0);
        check("flush_stage0", 32'(bus.stage), 32'd0);
        step(0, 16'h0000, 0, 0, 0);
        check("flush_not_stored", 32'(bus.inst_valid), 32'd0);

        step(1, 16'h8123, 0, 0, 0);
        step(0, 16'h0000, 1, 1, 0);
        check("flush_done_pulse", 32'(bus.inst_done), 32'd1);
        step(0, 16'h0000, 0, 0, 0);
        check("flush_done_empty", 32'(bus.inst_valid), 32'd0);

        step(1, 16'h2041, 0, 0, 0);
        step(0, 16'h0000, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 0);
        check("async_pre_stage", 32'(bus.stage), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("async_stage", 32'(bus.stage), 32'd0);
        check("async_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("async_push_ret", 32'(bus.push_ret), 32'd0);
        check("async_final", 32'(bus.final_stage), 32'd1);
        check("async_inst_done", 32'(bus.inst_done), 32'd0);
        check("async_in_ready", 32'(bus.in_ready), 32'd1);
        step(0, 16'h0000, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 0);
        reset_n = 1'b1;

        step(1, 16'h8123, 0, 0, 0);
        step(0, 16'h0000, 0, 1, 0);
        check("post_reset_done", 32'(bus.inst_done), 32'd1);
        step(0, 16'h0000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_stage_sequencer.md
Name: inst_stage_sequencer

Overview:
- Front end of the decoder: buffers fetched 16-bit instructions in a small FIFO and presents the head instruction to the scheduler.
- Sequences multi-stage instructions through a parametrised number of micro-stages. This generalises the fixed two-stage call scheme (push, then jump) to CALL_STAGES stages.
- Gates immediate-data consumption to the final stage.
- Sits between prefetch and the decoder/scheduler.

Parameters:
INST_BITS, 16, instruction width
QUEUE_DEPTH, 2, FIFO entries; power of two, >=1
STAGE_BITS, 2, width of the stage counter
CALL_STAGES, 2, stages executed by a call; 2..2^STAGE_BITS

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  prefetch offers in_inst
in_inst  input  INST_BITS  instruction from prefetch
in_ready  output  1  FIFO accepts in_inst this cycle
flush  input  1  discard all buffered instructions (taken jump/branch)
inst_valid  output  1  head instruction valid to scheduler
inst  output  INST_BITS  head instruction
stage  output  STAGE_BITS  current micro-stage index of head
final_stage  output  1  stage == last stage of head
push_ret  output  1  head is a call and not in final stage
sc_stage_done  input  1  scheduler finished current stage
inst_done  output  1  head instruction fully retired (pulse)
sc_next_imm_data  input  1  scheduler wants next immediate chunk
next_imm_data  output  1  gated immediate advance to prefetch

Behaviour:
- Reset is asynchronous: reset_n low clears count, rd/wr pointers and stage.
- Reset values:
  - inst_valid=0, in_ready=1, stage=0, inst_done=0, next_imm_data=0, push_ret=0.
  - final_stage=1 and inst echoes the (don't-care) head slot.
- Classification, combinational on head:
  - call iff inst[15:6]==10'b0010000001, giving last = CALL_STAGES-1.
  - Otherwise last = 0 (single-stage).
- FIFO handshake:
  - in_ready = !full && !flush.
  - Push on in_valid && in_ready.
  - inst_valid = !empty; inst = head entry.
  - No pass-through when full.
- Stage FSM:
  - Runs per head, from stage 0 up to last.
  - sc_stage_done is ignored when !inst_valid.
  - sc_stage_done with stage<last: stage<=stage+1 next cycle.
  - sc_stage_done with stage==last: inst_done=1 in the same cycle (combinational), head popped, stage<=0.
- final_stage = (stage==last); push_ret = call && !final_stage.
- next_imm_data = sc_next_imm_data && inst_valid && final_stage. Non-final stages never consume immediate data.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH.
- flush:
  - Next cycle: count=0, pointers equal, stage=0.
  - Overrides push (in_ready already low) and pop.
  - inst_done is still asserted that cycle if its condition holds.
- Reset asserted mid-instruction drops the stage and FIFO immediately. No pulse is emitted.

Optional Feature:
INST_BYPASS_EN
- Defined: when the FIFO is empty and in_valid is high, inst_valid=1 and inst=in_inst in the same cycle (zero-latency bypass).
  - A single-stage sc_stage_done in that cycle retires the instruction without it being written to the FIFO.
  - Otherwise it is written normally.
- Undefined: a pushed instruction becomes visible one cycle after the push.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> in_ready=1, inst_valid=0, stage=0; release, push 16'h8123 -> inst_valid=1 next cycle, final_stage=1, push_ret=0.
- Call sequencing, CALL_STAGES=3: push 16'h2041, pulse sc_stage_done 3x -> stage 0->1->2, push_ret=1 for stages 0,1; inst_done only on the third pulse.
- Imm gating: head call at stage 0, sc_next_imm_data=1 -> next_imm_data=0; at final stage -> next_imm_data=1.
- Full FIFO, QUEUE_DEPTH=2: push 2 without retire -> in_ready=0; retire one while pushing -> order preserved, count stays 1.
- Flush: 2 queued, head call at stage 1, flush=1 with in_valid=1 -> next cycle inst_valid=0, stage=0, pushed word not stored.
- Async reset mid-call at stage 1 -> outputs return to reset values without a clk edge; no inst_done pulse.
